// File: rtl/fifo_rptr_level.sv
// Read-side pointer controller for the asynchronous FIFO (read clock domain).
// Produces the memory read address, the Gray read pointer and registered status flags.
module fifo_rptr_level #(
    parameter int ADDR_WIDTH   = 4,
    parameter int AEMPTY_LEVEL = 2
) (
    input  logic                  R_CLK,
    input  logic                  R_rst_n,
    input  logic                  R_inc,
    input  logic                  R_flush,
    input  logic                  R_err_clr,
    input  logic [ADDR_WIDTH:0]   Rq2_wptr,
    output logic [ADDR_WIDTH:0]   R_ptr,
    output logic [ADDR_WIDTH-1:0] R_Addr,
    output logic                  R_empty,
    output logic                  R_aempty,
    output logic [ADDR_WIDTH:0]   R_level,
    output logic                  R_underflow
);

    localparam logic [ADDR_WIDTH:0] AE_LVL = (ADDR_WIDTH + 1)'(AEMPTY_LEVEL);

    logic [ADDR_WIDTH:0] rbin_q, rbin_d;
    logic [ADDR_WIDTH:0] rptr_q, rptr_d;
    logic [ADDR_WIDTH:0] level_q, level_d;
    logic                empty_q, empty_d;
    logic                aempty_q, aempty_d;
    logic                uflow_q, uflow_d;
    logic [ADDR_WIDTH:0] wbin;
    logic                pop;

    // Gray-to-binary of the synchronised write pointer, prefix XOR from the MSB
    always_comb begin
        wbin = '0;
        wbin[ADDR_WIDTH] = Rq2_wptr[ADDR_WIDTH];
        for (int i = ADDR_WIDTH - 1; i >= 0; i--) begin
            wbin[i] = wbin[i+1] ^ Rq2_wptr[i];
        end
    end

    always_comb begin
        pop      = R_inc & ~empty_q & ~R_flush;
        rbin_d   = R_flush ? wbin
                           : rbin_q + {{ADDR_WIDTH{1'b0}}, pop};
        rptr_d   = (rbin_d >> 1) ^ rbin_d;
        level_d  = wbin - rbin_d;
        empty_d  = (rptr_d == Rq2_wptr);
        aempty_d = (level_d <= AE_LVL);
        // Set wins over clear; flush cycles never record underflow
        uflow_d  = (R_inc & empty_q & ~R_flush)
                 | (uflow_q & ~R_err_clr);
    end

    always_ff @(posedge R_CLK) begin
        if (!R_rst_n) begin
            rbin_q   <= '0;
            rptr_q   <= '0;
            level_q  <= '0;
            empty_q  <= 1'b1;
            aempty_q <= 1'b1;
            uflow_q  <= 1'b0;
        end else begin
            rbin_q   <= rbin_d;
            rptr_q   <= rptr_d;
            level_q  <= level_d;
            empty_q  <= empty_d;
            aempty_q <= aempty_d;
            uflow_q  <= uflow_d;
        end
    end

    assign R_ptr       = rptr_q;
    assign R_Addr      = rbin_q[ADDR_WIDTH-1:0];
    assign R_empty     = empty_q;
    assign R_aempty    = aempty_q;
    assign R_level     = level_q;
    assign R_underflow = uflow_q;

endmodule

// File: tb/tb_fifo_rptr_level.sv
// Bench for fifo_rptr_level: directed steps plus random traffic on two
// instances, checked against an arithmetic pointer-count model.
module tb_fifo_rptr_level;

    logic       clk = 1'b0;
    logic       rst_n, inc, flush, clr;
    logic [4:0] wq_a;
    logic [3:0] wq_b;
    logic [4:0] ptr_a, lvl_a;
    logic [3:0] addr_a;
    logic       empty_a, aempty_a, uf_a;
    logic [3:0] ptr_b, lvl_b;
    logic [2:0] addr_b;
    logic       empty_b, aempty_b, uf_b;

    int passed = 0;
    int total  = 0;

    int r_a, w_a, l_a, r_b, w_b, l_b;
    bit e_a, ae_a, u_a, p_a, e_b, ae_b, u_b, p_b;
    logic [4:0] pp_a;
    logic [3:0] pp_b;

    always #5 clk = ~clk;

    always_comb wq_a = 5'(w_a ^ (w_a >> 1));
    always_comb wq_b = 4'(w_b ^ (w_b >> 1));

    fifo_rptr_level #(.ADDR_WIDTH(4), .AEMPTY_LEVEL(2)) dut_a (
        .R_CLK(clk), .R_rst_n(rst_n), .R_inc(inc), .R_flush(flush),
        .R_err_clr(clr), .Rq2_wptr(wq_a), .R_ptr(ptr_a), .R_Addr(addr_a),
        .R_empty(empty_a), .R_aempty(aempty_a), .R_level(lvl_a),
        .R_underflow(uf_a)
    );

    fifo_rptr_level #(.ADDR_WIDTH(3), .AEMPTY_LEVEL(0)) dut_b (
        .R_CLK(clk), .R_rst_n(rst_n), .R_inc(inc), .R_flush(flush),
        .R_err_clr(clr), .Rq2_wptr(wq_b), .R_ptr(ptr_b), .R_Addr(addr_b),
        .R_empty(empty_b), .R_aempty(aempty_b), .R_level(lvl_b),
        .R_underflow(uf_b)
    );

    function automatic int gray(input int b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Read count r and write count w live modulo 2*depth; level is their distance
    task automatic model(input int aw, input int ae, input int w,
                         inout int r, inout bit e, inout bit aef,
                         inout bit uf, inout int l, output bit popped);
        int d2;
        bit setu;
        d2 = 1 << (aw + 1);
        popped = 1'b0;
        if (!rst_n) begin
            r = 0; e = 1; aef = 1; uf = 0; l = 0;
        end else begin
            setu = inc && e && !flush;
            if (flush) r = w;
            else if (inc && !e) begin
                r = (r + 1) % d2;
                popped = 1'b1;
            end
            uf  = setu || (uf && !clr);
            l   = (w - r + d2) % d2;
            e   = (l == 0);
            aef = (l <= ae);
        end
    endtask

    task automatic step();
        pp_a = ptr_a;
        pp_b = ptr_b;
        @(posedge clk);
        model(4, 2, w_a, r_a, e_a, ae_a, u_a, l_a, p_a);
        model(3, 0, w_b, r_b, e_b, ae_b, u_b, l_b, p_b);
        #1;
        chk("a_ptr", 32'(ptr_a), 32'(gray(r_a)));
        chk("a_addr", 32'(addr_a), 32'(r_a % 16));
        chk("a_empty", 32'(empty_a), 32'(e_a));
        chk("a_aempty", 32'(aempty_a), 32'(ae_a));
        chk("a_level", 32'(lvl_a), 32'(l_a));
        chk("a_uflow", 32'(uf_a), 32'(u_a));
        chk("b_ptr", 32'(ptr_b), 32'(gray(r_b)));
        chk("b_addr", 32'(addr_b), 32'(r_b % 8));
        chk("b_empty", 32'(empty_b), 32'(e_b));
        chk("b_aempty", 32'(aempty_b), 32'(ae_b));
        chk("b_level", 32'(lvl_b), 32'(l_b));
        chk("b_uflow", 32'(uf_b), 32'(u_b));
        if (p_a) chk("a_gray1bit", 32'($countones(ptr_a ^ pp_a)), 32'd1);
        if (p_b) chk("b_gray1bit", 32'($countones(ptr_b ^ pp_b)), 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        w_a = 0;
        w_b = 0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        int lv, room, pace;
        rst_n = 1'b0; inc = 1'b0; flush = 1'b0; clr = 1'b0;
        w_a = 0; w_b = 0;
        r_a = 0; r_b = 0; l_a = 0; l_b = 0;
        e_a = 1; e_b = 1; ae_a = 1; ae_b = 1; u_a = 0; u_b = 0;
        do_reset();
        chk("rst_empty", 32'(empty_a), 32'd1);
        chk("rst_aempty", 32'(aempty_a), 32'd1);

        inc = 1'b1;
        repeat (3) begin
            step();
            chk("p1_uflow", 32'(uf_a), 32'd1);
            chk("p1_addr", 32'(addr_a), 32'd0);
        end
        inc = 1'b0;
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("p1_clr", 32'(uf_a), 32'd0);

        w_a = 5;
        step();
        chk("p2_level5", 32'(lvl_a), 32'd5);
        chk("p2_aempty0", 32'(aempty_a), 32'd0);
        inc = 1'b1;
        repeat (3) step();
        chk("p2_level2", 32'(lvl_a), 32'd2);
        chk("p2_aempty1", 32'(aempty_a), 32'd1);
        repeat (2) step();
        inc = 1'b0;
        chk("p2_empty", 32'(empty_a), 32'd1);
        chk("p2_ptr", 32'(ptr_a), 32'b00111);
        chk("p2_addr", 32'(addr_a), 32'd5);

        do_reset();
        inc = 1'b1;
        for (int i = 1; i <= 36; i++) begin
            w_a = i % 32;
            step();
            if (i == 17) chk("p3_ptr16", 32'(ptr_a), 32'b11000);
            if (i >= 3) chk("p5_level1", 32'(lvl_a), 32'd1);
        end
        inc = 1'b0;

        do_reset();
        w_a = 9;
        step();
        inc = 1'b1;
        repeat (2) step();
        chk("p4_level7", 32'(lvl_a), 32'd7);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("p4_empty", 32'(empty_a), 32'd1);
        chk("p4_level0", 32'(lvl_a), 32'd0);
        chk("p4_addr9", 32'(addr_a), 32'd9);
        chk("p4_ptr", 32'(ptr_a), 32'b01101);
        chk("p4_uflow", 32'(uf_a), 32'd0);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("p5_setwins", 32'(uf_a), 32'd1);
        inc = 1'b0;

        w_b = (r_b + 8) % 16;
        step();
        chk("p6_full", 32'(lvl_b), 32'b1000);
        chk("p6_aempty", 32'(aempty_b), 32'd0);

        for (int n = 0; n < 600; n++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            pace  = $urandom_range(0, 3);
            inc   = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 24) == 0);
            clr   = ($urandom_range(0, 7) == 0);
            if (!rst_n) begin
                w_a = 0;
                w_b = 0;
            end else begin
                lv   = (w_a - r_a + 32) % 32;
                room = 16 - lv;
                w_a  = (w_a + ((pace < room) ? pace : room)) % 32;
                lv   = (w_b - r_b + 16) % 16;
                room = 8 - lv;
                w_b  = (w_b + ((pace < room) ? pace : room)) % 16;
            end
            step();
        end
        rst_n = 1'b1;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
